morse_decoder: RTL and testbench

- Parametrised Morse decoder, successor to the single-letter trie decoder.
- Takes single-cycle dot/dash/done strobes from the existing debouncer edge outputs and accumulates a variable-length symbol code. It closes the code on a done strobe or on an inter-letter timeout, then translates it to ASCII (A-Z, 0-9, optional punctuation) through a lookup sub-module.
- Delivers each character on a valid/ready output port with error and overrun reporting. It also emits an automatic space on a word gap.
- Sits between the button debouncers and the character consumer (display/UART buffer).

---
 rtl/morse_pkg.sv | 17 +
 rtl/morse_lut.sv | 76 +++++++
 rtl/morse_decoder.sv | 151 +++++++++++++++
 tb/tb_morse_decoder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared constants and helpers for the Morse decoder.
// Symbol encoding, ASCII codes and field widths.
package morse_pkg;

  localparam logic [7:0] CH_SPACE   = 8'h20;
  localparam logic [7:0] CH_UNKNOWN = 8'h3F;

  typedef enum logic {
    SYM_DOT  = 1'b0,
    SYM_DASH = 1'b1
  } sym_e;

  function automatic int len_w(input int max_sym);
    return $clog2(max_sym + 1);
  endfunction

endpackage

// File: rtl/morse_lut.sv
// Combinational {len, code} to ASCII table.
// ascii == 0 means the code is not assigned.
module morse_lut
  import morse_pkg::*;
#(
  parameter int MAX_SYMBOLS = 5,
  parameter int PUNCT_EN    = 1
) (
  input  logic [len_w(MAX_SYMBOLS)-1:0] len,
  input  logic [MAX_SYMBOLS-1:0]        code,
  output logic                          hit,
  output logic [7:0]                    ascii
);

  localparam bit PUNCT = (PUNCT_EN != 0) && (MAX_SYMBOLS >= 6);

  logic [7:0]  c8;
  logic [11:0] key;

  // Bits above len are always zero, so the full key is matched.
  always_comb begin
    c8 = '0;
    c8[MAX_SYMBOLS-1:0] = code;
    key = {4'(len), c8};
    ascii = 8'h00;
    case (key)
      {4'd1, 8'b0}:     ascii = "E";
      {4'd1, 8'b1}:     ascii = "T";
      {4'd2, 8'b00}:    ascii = "I";
      {4'd2, 8'b01}:    ascii = "A";
      {4'd2, 8'b10}:    ascii = "N";
      {4'd2, 8'b11}:    ascii = "M";
      {4'd3, 8'b000}:   ascii = "S";
      {4'd3, 8'b001}:   ascii = "U";
      {4'd3, 8'b010}:   ascii = "R";
      {4'd3, 8'b011}:   ascii = "W";
      {4'd3, 8'b100}:   ascii = "D";
      {4'd3, 8'b101}:   ascii = "K";
      {4'd3, 8'b110}:   ascii = "G";
      {4'd3, 8'b111}:   ascii = "O";
      {4'd4, 8'b0000}:  ascii = "H";
      {4'd4, 8'b0001}:  ascii = "V";
      {4'd4, 8'b0010}:  ascii = "F";
      {4'd4, 8'b0100}:  ascii = "L";
      {4'd4, 8'b0110}:  ascii = "P";
      {4'd4, 8'b0111}:  ascii = "J";
      {4'd4, 8'b1000}:  ascii = "B";
      {4'd4, 8'b1001}:  ascii = "X";
      {4'd4, 8'b1010}:  ascii = "C";
      {4'd4, 8'b1011}:  ascii = "Y";
      {4'd4, 8'b1100}:  ascii = "Z";
      {4'd4, 8'b1101}:  ascii = "Q";
      {4'd5, 8'b01111}: ascii = "1";
      {4'd5, 8'b00111}: ascii = "2";
      {4'd5, 8'b00011}: ascii = "3";
      {4'd5, 8'b00001}: ascii = "4";
      {4'd5, 8'b00000}: ascii = "5";
      {4'd5, 8'b10000}: ascii = "6";
      {4'd5, 8'b11000}: ascii = "7";
      {4'd5, 8'b11100}: ascii = "8";
      {4'd5, 8'b11110}: ascii = "9";
      {4'd5, 8'b11111}: ascii = "0";
      default:          ascii = 8'h00;
    endcase
    if (PUNCT) begin
      case (key)
        {4'd6, 8'b010101}: ascii = ".";
        {4'd6, 8'b110011}: ascii = ",";
        {4'd6, 8'b001100}: ascii = "?";
        default:           ;
      endcase
    end
    hit = (ascii != 8'h00);
  end

endmodule

// File: rtl/morse_decoder.sv
// Morse symbol collector with letter/word gap timing
// and a single-entry valid/ready output register.
module morse_decoder
  import morse_pkg::*;
#(
  parameter int MAX_SYMBOLS = 5,
  parameter int LETTER_GAP  = 0,
  parameter int WORD_GAP    = 0,
  parameter int PUNCT_EN    = 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 dot,
  input  logic                                 dash,
  input  logic                                 done,
  input  logic                                 out_ready,
  output logic [7:0]                           out_char,
  output logic                                 out_valid,
  output logic                                 out_err,
  output logic                                 overrun,
  output logic                                 busy,
  output logic [$clog2(MAX_SYMBOLS+1)-1:0]     cur_len
);

  localparam int LEN_W   = len_w(MAX_SYMBOLS);
  localparam int GAP_MAX = (LETTER_GAP > WORD_GAP) ? LETTER_GAP : WORD_GAP;
  localparam int GAP_W   = (GAP_MAX < 1) ? 1 : $clog2(GAP_MAX + 1);

  logic [MAX_SYMBOLS-1:0] sym_code_q, sym_code_d;
  logic [LEN_W-1:0]       sym_len_q, sym_len_d;
  logic                   ovf_q, ovf_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic                   word_pend_q, word_pend_d;
  logic [7:0]             out_char_q, out_char_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_err_q, out_err_d;
  logic                   overrun_q, overrun_d;

  logic                   has, lg_hit, wg_hit, fin, sym_ev;
  logic                   sym_bit;
  logic                   lut_hit;
  logic [7:0]             lut_char;
  logic                   prod, prod_err;
  logic [7:0]             prod_char;
  logic [MAX_SYMBOLS-1:0] code_b;
  logic [LEN_W-1:0]       len_b;
  logic                   ovf_b;

  morse_lut #(
    .MAX_SYMBOLS (MAX_SYMBOLS),
    .PUNCT_EN    (PUNCT_EN)
  ) u_lut (
    .len   (sym_len_q),
    .code  (sym_code_q),
    .hit   (lut_hit),
    .ascii (lut_char)
  );

  // Letter close and word space triggers.
  always_comb begin
    has    = (sym_len_q != '0);
    lg_hit = (LETTER_GAP != 0) && has
          && (gap_q == GAP_W'(LETTER_GAP));
    fin    = has && (done || lg_hit);
    wg_hit = (WORD_GAP != 0) && word_pend_q && !has
          && (gap_q == GAP_W'(WORD_GAP));
    sym_ev  = !done && (dot || dash);
    sym_bit = dash ? SYM_DASH : SYM_DOT;
  end

  // Collector: a closing letter restarts from empty, then takes the symbol.
  always_comb begin
    code_b = fin ? '0 : sym_code_q;
    len_b  = fin ? '0 : sym_len_q;
    ovf_b  = fin ? 1'b0 : ovf_q;
    sym_code_d = code_b;
    sym_len_d  = len_b;
    ovf_d      = ovf_b;
    gap_d      = gap_q;
    if (sym_ev) begin
      gap_d = '0;
      if (len_b < LEN_W'(MAX_SYMBOLS)) begin
        sym_code_d = {code_b[MAX_SYMBOLS-2:0], sym_bit};
        sym_len_d  = len_b + LEN_W'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end else if ((has || word_pend_q)
              && (gap_q != GAP_W'(GAP_MAX))) begin
      gap_d = gap_q + GAP_W'(1);
    end
    word_pend_d = word_pend_q;
    if (fin) word_pend_d = 1'b1;
    else if (wg_hit) word_pend_d = 1'b0;
  end

  // Output register with drop-on-full and overrun pulse.
  always_comb begin
    prod      = fin || wg_hit;
    prod_err  = !wg_hit && (ovf_q || !lut_hit);
    prod_char = wg_hit ? CH_SPACE
              : (prod_err ? CH_UNKNOWN : lut_char);
    out_char_d  = out_char_q;
    out_err_d   = out_err_q;
    out_valid_d = out_valid_q;
    overrun_d   = 1'b0;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (prod) begin
      if (!out_valid_q || out_ready) begin
        out_char_d  = prod_char;
        out_err_d   = prod_err;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sym_code_q  <= '0;
      sym_len_q   <= '0;
      ovf_q       <= 1'b0;
      gap_q       <= '0;
      word_pend_q <= 1'b0;
      out_char_q  <= 8'h00;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sym_code_q  <= sym_code_d;
      sym_len_q   <= sym_len_d;
      ovf_q       <= ovf_d;
      gap_q       <= gap_d;
      word_pend_q <= word_pend_d;
      out_char_q  <= out_char_d;
      out_valid_q <= out_valid_d;
      out_err_q   <= out_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_char  = out_char_q;
  assign out_valid = out_valid_q;
  assign out_err   = out_err_q;
  assign overrun   = overrun_q;
  assign busy      = (sym_len_q != '0);
  assign cur_len   = sym_len_q;

endmodule

// File: tb/tb_morse_decoder.sv
// Directed bench for morse_decoder: letter table,
// timeouts, backpressure, priority and reset.
module tb_morse_decoder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic dot = 1'b0, dash = 1'b0, done = 1'b0, rdy = 1'b1;
  logic d1_dot = 1'b0, d1_dash = 1'b0, d1_done = 1'b0;
  logic d1_ready = 1'b1;

  logic [7:0] o0_char, o1_char, o2_char;
  logic       o0_valid, o0_err, o0_ovr, o0_busy;
  logic       o1_valid, o1_err, o1_ovr, o1_busy;
  logic       o2_valid, o2_err, o2_ovr, o2_busy;
  logic [2:0] o0_len, o1_len, o2_len;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  morse_decoder #(.MAX_SYMBOLS(5)) dut0 (
    .clk(clk), .reset(reset), .dot(dot), .dash(dash),
    .done(done), .out_ready(rdy), .out_char(o0_char),
    .out_valid(o0_valid), .out_err(o0_err),
    .overrun(o0_ovr), .busy(o0_busy), .cur_len(o0_len)
  );

  morse_decoder #(
    .MAX_SYMBOLS(5), .LETTER_GAP(100), .WORD_GAP(300)
  ) dut1 (
    .clk(clk), .reset(reset), .dot(d1_dot), .dash(d1_dash),
    .done(d1_done), .out_ready(d1_ready), .out_char(o1_char),
    .out_valid(o1_valid), .out_err(o1_err),
    .overrun(o1_ovr), .busy(o1_busy), .cur_len(o1_len)
  );

  morse_decoder #(.MAX_SYMBOLS(6), .PUNCT_EN(1)) dut2 (
    .clk(clk), .reset(reset), .dot(dot), .dash(dash),
    .done(done), .out_ready(rdy), .out_char(o2_char),
    .out_valid(o2_valid), .out_err(o2_err),
    .overrun(o2_ovr), .busy(o2_busy), .cur_len(o2_len)
  );

  typedef struct {
    string      name;
    string      code;
    logic [7:0] ch;
    logic       err;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse(input logic pd, input logic pa,
                       input logic pn);
    dot = pd; dash = pa; done = pn;
    @(negedge clk);
    dot = 1'b0; dash = 1'b0; done = 1'b0;
  endtask

  task automatic send(input string code);
    for (int j = 0; j < code.len(); j++) begin
      if (code[j] == "-") pulse(1'b0, 1'b1, 1'b0);
      else pulse(1'b1, 1'b0, 1'b0);
    end
    pulse(1'b0, 1'b0, 1'b1);
  endtask

  int nval, at0, at1;
  logic [7:0] ch0, ch1;
  logic err1;

  initial begin
    vecs[0]  = '{"A",   ".-",     8'h41, 1'b0};
    vecs[1]  = '{"E",   ".",      8'h45, 1'b0};
    vecs[2]  = '{"T",   "-",      8'h54, 1'b0};
    vecs[3]  = '{"d5",  ".....",  8'h35, 1'b0};
    vecs[4]  = '{"ovf", "......", 8'h3F, 1'b1};
    vecs[5]  = '{"unk", "-.--.",  8'h3F, 1'b1};
    vecs[6]  = '{"d0",  "-----",  8'h30, 1'b0};
    vecs[7]  = '{"Z",   "--..",   8'h5A, 1'b0};
    vecs[8]  = '{"d1",  ".----",  8'h31, 1'b0};
    vecs[9]  = '{"V",   "...-",   8'h56, 1'b0};
    vecs[10] = '{"unk4", ".-.-",  8'h3F, 1'b1};
    vecs[11] = '{"Q",   "--.-",   8'h51, 1'b0};

    @(negedge clk);
    @(negedge clk);
    chk("rst_char", o0_char, 0);
    chk("rst_valid", o0_valid, 0);
    chk("rst_err", o0_err, 0);
    chk("rst_ovr", o0_ovr, 0);
    chk("rst_busy", o0_busy, 0);
    chk("rst_len", o0_len, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      send(vecs[i].code);
      chk({vecs[i].name, "_valid"}, o0_valid, 1);
      chk({vecs[i].name, "_char"}, o0_char, vecs[i].ch);
      chk({vecs[i].name, "_err"}, o0_err, vecs[i].err);
      chk({vecs[i].name, "_len"}, o0_len, 0);
      @(negedge clk);
      chk({vecs[i].name, "_1cyc"}, o0_valid, 0);
    end

    send(".-.-.-");
    chk("punct_valid", o2_valid, 1);
    chk("punct_char", o2_char, 8'h2E);
    chk("punct_err", o2_err, 0);
    @(negedge clk);

    pulse(1'b1, 1'b1, 1'b0);
    chk("prio_len", o0_len, 1);
    pulse(1'b0, 1'b0, 1'b1);
    chk("prio_char", o0_char, 8'h54);
    chk("prio_valid", o0_valid, 1);
    @(negedge clk);
    pulse(1'b1, 1'b0, 1'b1);
    chk("done_empty_valid", o0_valid, 0);
    chk("done_dot_len", o0_len, 0);

    rdy = 1'b0;
    send(".");
    chk("bp_e_valid", o0_valid, 1);
    chk("bp_e_char", o0_char, 8'h45);
    send("-");
    chk("bp_ovr", o0_ovr, 1);
    chk("bp_keep", o0_char, 8'h45);
    chk("bp_vhold", o0_valid, 1);
    @(negedge clk);
    chk("bp_ovr_once", o0_ovr, 0);
    rdy = 1'b1;
    @(negedge clk);
    chk("bp_consumed", o0_valid, 0);
    nval = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (o0_valid) nval++;
    end
    chk("bp_no_t", nval, 0);

    rdy = 1'b0;
    send(".");
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    chk("mid_busy", o0_busy, 1);
    chk("mid_len", o0_len, 2);
    reset = 1'b1;
    #1;
    chk("mr_valid", o0_valid, 0);
    chk("mr_char", o0_char, 0);
    chk("mr_busy", o0_busy, 0);
    chk("mr_len", o0_len, 0);
    chk("mr_err", o0_err, 0);
    chk("mr_ovr", o0_ovr, 0);
    @(negedge clk);
    reset = 1'b0;
    rdy = 1'b1;
    @(negedge clk);
    send(".");
    chk("mr_e_char", o0_char, 8'h45);
    chk("mr_e_valid", o0_valid, 1);
    nval = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (o0_valid) nval++;
    end
    chk("mr_only_e", nval, 0);

    nval = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (o1_valid) nval++;
    end
    chk("to_no_space", nval, 0);

    d1_dash = 1'b1;
    nval = 0; at0 = -1; at1 = -1;
    ch0 = 8'h00; ch1 = 8'h00; err1 = 1'b1;
    for (int k = 0; k <= 700; k++) begin
      @(negedge clk);
      d1_dash = 1'b0;
      if (o1_valid) begin
        if (nval == 0) begin
          at0 = k; ch0 = o1_char;
        end else if (nval == 1) begin
          at1 = k; ch1 = o1_char; err1 = o1_err;
        end
        nval++;
      end
    end
    chk("to_t_cycle", at0, 101);
    chk("to_t_char", ch0, 8'h54);
    chk("to_sp_cycle", at1, 301);
    chk("to_sp_char", ch1, 8'h20);
    chk("to_sp_err", err1, 0);
    chk("to_count", nval, 2);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
